xrisc_store_checker: RTL and testbench
======================================

XRISC_STORE_CHECKER -- requirements
Module: xrisc_store_checker

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning): DATA_W 32 store data width; ADDR_W 32 store address width; N_EXP 8 expected-store table depth; TIMEOUT 240 cycle budget per run.
REQ-002 Ports SHALL be (name direction width meaning): clk in 1 clock, rising edge; reset in 1 asynchronous active-low reset; mem_write in 1 core store strobe; data_adr in ADDR_W store address; write_data in DATA_W store data.
REQ-003 Config ports SHALL be: cfg_we in 1 table write; cfg_idx in IDX_W table index; cfg_adr in ADDR_W expected address; cfg_data in DATA_W expected data; cfg_count in IDX_W+1 number of expected stores; start in 1 run pulse; clear in 1 return-to-idle pulse.
REQ-004 Status ports SHALL be: busy out 1; done out 1; pass out 1; fail_code out 2 (0 none, 1 mismatch, 2 timeout, 3 badcfg); mismatch_idx out IDX_W; store_count out IDX_W+1; cycle_count out CNT_W; last_adr out ADDR_W; last_data out DATA_W.
REQ-005 IDX_W SHALL be max(1,$clog2(N_EXP)); CNT_W SHALL be $clog2(TIMEOUT+1).

Function
REQ-006 FSM states SHALL be IDLE, RUN, PASS, FAIL; busy=1 only in RUN; done=1 in PASS or FAIL; pass=1 only in PASS.
REQ-007 In IDLE, cfg_we SHALL write {cfg_adr,cfg_data} to table[cfg_idx] at the clock edge; cfg_idx >= N_EXP SHALL be ignored; cfg_we outside IDLE SHALL be ignored.
REQ-008 start in IDLE with 1 <= cfg_count <= N_EXP SHALL latch cfg_count, clear ptr, store_count, cycle_count and fail_code, and enter RUN next cycle.
REQ-009 start in IDLE with cfg_count 0 or > N_EXP SHALL enter FAIL with fail_code 3.
REQ-010 In RUN, cycle_count SHALL increment by 1 every cycle, saturating at TIMEOUT.
REQ-011 In RUN, mem_write with {data_adr,write_data} equal to table[ptr] SHALL increment ptr and store_count; if ptr == count-1, next state SHALL be PASS.
REQ-012 In RUN, mem_write with any mismatch SHALL enter FAIL with fail_code 1 and mismatch_idx=ptr; store_count unchanged.
REQ-013 In RUN, reaching cycle_count == TIMEOUT-1 with no completing store in that cycle SHALL enter FAIL with fail_code 2.
REQ-014 A completing matching store in the timeout cycle SHALL win: PASS.
REQ-015 Status outputs SHALL be registered; state change visible one cycle after the deciding edge.
REQ-016 PASS and FAIL SHALL hold all status until clear, then go to IDLE; start in RUN, PASS or FAIL SHALL be ignored; clear in RUN SHALL abort to IDLE with fail_code 0.
REQ-017 Simultaneous start and clear in IDLE: clear SHALL take priority (stay IDLE).
REQ-018 The table contents SHALL persist across runs and clear.

Reset
REQ-019 reset low SHALL asynchronously force IDLE and zero all status outputs, ptr and counters; table contents SHALL NOT be reset.
REQ-020 Reset mid-RUN SHALL abandon the run without reporting done.

Configuration
REQ-021 With XRISC_CHK_LAST_EN defined, every mem_write in RUN SHALL capture data_adr/write_data into last_adr/last_data, cleared on start.
REQ-022 Without XRISC_CHK_LAST_EN, last_adr/last_data SHALL be constant 0 and no capture registers SHALL exist.

Structure
REQ-023 A shared package xrisc_chk_pkg SHALL hold the state enum and the fail_code constants FC_NONE, FC_MISMATCH, FC_TIMEOUT, FC_BADCFG.
REQ-024 The expected-store table SHALL be one sub-module xrisc_chk_table (N_EXP x (ADDR_W+DATA_W), one write port, one async read port).

Verification
REQ-025 Pass: table[0]=(100,25), count 1, start; store (100,25) at RUN cycle 20 -> pass=1, done=1, store_count=1, fail_code=0.
REQ-026 Mismatch: table[0]=(84,7), table[1]=(100,25), count 2; stores (84,7),(100,24) -> FAIL, fail_code=1, mismatch_idx=1, store_count=1.
REQ-027 Timeout: TIMEOUT=240, count 1, no stores -> FAIL, fail_code=2, cycle_count=239 on entry; matching store exactly on cycle 239 -> PASS.
REQ-028 Badcfg: start with cfg_count=0 and with cfg_count=9 (N_EXP=8) -> FAIL, fail_code=3, cycle_count=0.
REQ-029 Reset mid-RUN after 1 of 2 matching stores -> all status 0, IDLE; new start with unchanged table passes without re-config.
REQ-030 Clear in PASS -> IDLE next cycle, done=0; start+clear same cycle in IDLE -> stays IDLE.

Source files
------------

// File: rtl/xrisc_chk_pkg.sv
// Shared types for the store checker: FSM states, fail codes,
// and the index-width helper used by the top and the table.
package xrisc_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } chk_state_e;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISMATCH = 2'd1;
    localparam logic [1:0] FC_TIMEOUT  = 2'd2;
    localparam logic [1:0] FC_BADCFG   = 2'd3;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xrisc_chk_table.sv
// Expected-store table: N_EXP entries of W bits, one sync write port,
// one async read port. Contents are deliberately not reset.
// Ports: clk, we_i/widx_i/wdata_i (write), ridx_i/rdata_o (read).
module xrisc_chk_table #(
    parameter int N_EXP = 8,
    parameter int W     = 64,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] widx_i,
    input  logic [W-1:0]     wdata_i,
    input  logic [IDX_W-1:0] ridx_i,
    output logic [W-1:0]     rdata_o
);

    logic [W-1:0] mem_q [N_EXP];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/xrisc_store_checker.sv
// Store checker: compares core stores against a programmed table of
// expected {address,data} pairs and reports pass/mismatch/timeout/badcfg.
// Ports: clk, reset (async active-low), mem_write/data_adr/write_data
// (core store), cfg_* / start / clear (config), busy/done/pass/fail_code/
// mismatch_idx/store_count/cycle_count/last_adr/last_data (status).
// Optional macro XRISC_CHK_LAST_EN enables last-store capture.
module xrisc_store_checker
    import xrisc_chk_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int N_EXP   = 8,
    parameter int TIMEOUT = 240,
    localparam int IDX_W  = idx_w(N_EXP),
    localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] data_adr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_adr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [IDX_W:0]    cfg_count,
    input  logic              start,
    input  logic              clear,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [IDX_W-1:0]  mismatch_idx,
    output logic [IDX_W:0]    store_count,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [ADDR_W-1:0] last_adr,
    output logic [DATA_W-1:0] last_data
);

    localparam int EW = ADDR_W + DATA_W;

    chk_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W:0]   count_q, count_d;
    logic [IDX_W:0]   store_q, store_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [1:0]       fc_q, fc_d;
    logic [IDX_W-1:0] midx_q, midx_d;
    logic             busy_q, done_q, pass_q;

    logic             tbl_we;
    logic [EW-1:0]    exp_entry;
    logic             idx_ok;
    logic             cnt_ok;
    logic             hit;
    logic             last_ptr;
    logic [CNT_W-1:0] cyc_inc;
    logic             go;

    assign idx_ok = 32'(cfg_idx) < N_EXP;
    assign cnt_ok = (cfg_count != '0) && (32'(cfg_count) <= N_EXP);
    assign tbl_we = (state_q == IDLE) && cfg_we && idx_ok;

    xrisc_chk_table #(
        .N_EXP (N_EXP),
        .W     (EW),
        .IDX_W (IDX_W)
    ) u_table (
        .clk     (clk),
        .we_i    (tbl_we),
        .widx_i  (cfg_idx),
        .wdata_i ({cfg_adr, cfg_data}),
        .ridx_i  (ptr_q),
        .rdata_o (exp_entry)
    );

    assign hit      = mem_write && (exp_entry == {data_adr, write_data});
    assign last_ptr = ({1'b0, ptr_q} == (count_q - 1'b1));
    assign cyc_inc  = (cyc_q == CNT_W'(TIMEOUT)) ? cyc_q : cyc_q + 1'b1;
    // clear outranks start in IDLE
    assign go       = (state_q == IDLE) && start && !clear;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        store_d = store_q;
        cyc_d   = cyc_q;
        fc_d    = fc_q;
        midx_d  = midx_q;
        unique case (state_q)
            IDLE: begin
                if (clear) begin
                    fc_d = FC_NONE;
                end else if (start) begin
                    ptr_d   = '0;
                    store_d = '0;
                    cyc_d   = '0;
                    midx_d  = '0;
                    if (cnt_ok) begin
                        state_d = RUN;
                        count_d = cfg_count;
                        fc_d    = FC_NONE;
                    end else begin
                        state_d = FAIL;
                        fc_d    = FC_BADCFG;
                    end
                end
            end
            RUN: begin
                if (clear) begin
                    state_d = IDLE;
                    fc_d    = FC_NONE;
                end else if (mem_write && !hit) begin
                    state_d = FAIL;
                    fc_d    = FC_MISMATCH;
                    midx_d  = ptr_q;
                    cyc_d   = cyc_inc;
                end else begin
                    if (hit) begin
                        ptr_d   = ptr_q + 1'b1;
                        store_d = store_q + 1'b1;
                    end
                    // a completing store beats the timeout in the same cycle
                    if (hit && last_ptr) begin
                        state_d = PASS;
                        cyc_d   = cyc_inc;
                    end else if (cyc_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d = FAIL;
                        fc_d    = FC_TIMEOUT;
                    end else begin
                        cyc_d = cyc_inc;
                    end
                end
            end
            PASS, FAIL: begin
                if (clear) begin
                    state_d = IDLE;
                    fc_d    = FC_NONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            store_q <= '0;
            cyc_q   <= '0;
            fc_q    <= FC_NONE;
            midx_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            store_q <= store_d;
            cyc_q   <= cyc_d;
            fc_q    <= fc_d;
            midx_q  <= midx_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == PASS) || (state_d == FAIL);
            pass_q  <= (state_d == PASS);
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign fail_code    = fc_q;
    assign mismatch_idx = midx_q;
    assign store_count  = store_q;
    assign cycle_count  = cyc_q;

`ifdef XRISC_CHK_LAST_EN
    logic [ADDR_W-1:0] last_adr_q;
    logic [DATA_W-1:0] last_data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_adr_q  <= '0;
            last_data_q <= '0;
        end else if (go) begin
            last_adr_q  <= '0;
            last_data_q <= '0;
        end else if ((state_q == RUN) && mem_write) begin
            last_adr_q  <= data_adr;
            last_data_q <= write_data;
        end
    end

    assign last_adr  = last_adr_q;
    assign last_data = last_data_q;
`else
    logic unused_go;
    assign unused_go = go;
    assign last_adr  = '0;
    assign last_data = '0;
`endif

endmodule

// File: tb/tb_xrisc_store_checker.sv
// Directed self-checking bench for xrisc_store_checker.
// One task per scenario; expected values are hand-derived.
module tb_xrisc_store_checker;

    localparam int IDX_W = 3;
    localparam int CNT_W = 8;

`ifdef XRISC_CHK_LAST_EN
    localparam logic [31:0] EXP_LA = 32'd100;
    localparam logic [31:0] EXP_LD = 32'd25;
`else
    localparam logic [31:0] EXP_LA = 32'd0;
    localparam logic [31:0] EXP_LD = 32'd0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             mem_write = 1'b0;
    logic [31:0]      data_adr = '0;
    logic [31:0]      write_data = '0;
    logic             cfg_we = 1'b0;
    logic [IDX_W-1:0] cfg_idx = '0;
    logic [31:0]      cfg_adr = '0;
    logic [31:0]      cfg_data = '0;
    logic [IDX_W:0]   cfg_count = '0;
    logic             start = 1'b0;
    logic             clear = 1'b0;
    logic             busy, done, pass;
    logic [1:0]       fail_code;
    logic [IDX_W-1:0] mismatch_idx;
    logic [IDX_W:0]   store_count;
    logic [CNT_W-1:0] cycle_count;
    logic [31:0]      last_adr, last_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    xrisc_store_checker dut (
        .clk          (clk),
        .reset        (rst_n),
        .mem_write    (mem_write),
        .data_adr     (data_adr),
        .write_data   (write_data),
        .cfg_we       (cfg_we),
        .cfg_idx      (cfg_idx),
        .cfg_adr      (cfg_adr),
        .cfg_data     (cfg_data),
        .cfg_count    (cfg_count),
        .start        (start),
        .clear        (clear),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .fail_code    (fail_code),
        .mismatch_idx (mismatch_idx),
        .store_count  (store_count),
        .cycle_count  (cycle_count),
        .last_adr     (last_adr),
        .last_data    (last_data)
    );

    // all drivers are entered and left at a falling edge
    task automatic cfg_write(input int idx, input int adr, input int dat);
        cfg_we = 1'b1; cfg_idx = IDX_W'(idx);
        cfg_adr = 32'(adr); cfg_data = 32'(dat);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input int cnt);
        start = 1'b1; cfg_count = (IDX_W+1)'(cnt);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_store(input int adr, input int dat);
        mem_write = 1'b1; data_adr = 32'(adr); write_data = 32'(dat);
        @(negedge clk);
        mem_write = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got=%0d exp=0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done got=%0d exp=0", done); end
        tests++; if (pass !== 1'b0) begin fails++; $display("FAIL rst_pass got=%0d exp=0", pass); end
        tests++; if (fail_code !== 2'd0) begin fails++; $display("FAIL rst_fc got=%0d exp=0", fail_code); end
        tests++; if (store_count !== 4'd0) begin fails++; $display("FAIL rst_sc got=%0d exp=0", store_count); end
        tests++; if (cycle_count !== 8'd0) begin fails++; $display("FAIL rst_cc got=%0d exp=0", cycle_count); end
        tests++; if (last_adr !== 32'd0) begin fails++; $display("FAIL rst_la got=%0d exp=0", last_adr); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_pass();
        cfg_write(0, 100, 25);
        do_start(1);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL pass_busy got=%0d exp=1", busy); end
        tests++; if (cycle_count !== 8'd0) begin fails++; $display("FAIL pass_cc0 got=%0d exp=0", cycle_count); end
        repeat (20) @(negedge clk);
        tests++; if (cycle_count !== 8'd20) begin fails++; $display("FAIL pass_cc20 got=%0d exp=20", cycle_count); end
        do_store(100, 25);
        tests++; if (pass !== 1'b1) begin fails++; $display("FAIL pass_pass got=%0d exp=1", pass); end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL pass_done got=%0d exp=1", done); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL pass_busy0 got=%0d exp=0", busy); end
        tests++; if (store_count !== 4'd1) begin fails++; $display("FAIL pass_sc got=%0d exp=1", store_count); end
        tests++; if (fail_code !== 2'd0) begin fails++; $display("FAIL pass_fc got=%0d exp=0", fail_code); end
        tests++; if (last_adr !== EXP_LA) begin fails++; $display("FAIL pass_la got=%0d exp=%0d", last_adr, EXP_LA); end
        tests++; if (last_data !== EXP_LD) begin fails++; $display("FAIL pass_ld got=%0d exp=%0d", last_data, EXP_LD); end
        // start is ignored in PASS and status holds
        do_start(1);
        repeat (3) @(negedge clk);
        tests++; if (pass !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL pass_hold pass=%0d busy=%0d exp=1,0", pass, busy); end
        do_clear();
        tests++; if (done !== 1'b0 || pass !== 1'b0) begin fails++; $display("FAIL pass_clear done=%0d pass=%0d exp=0,0", done, pass); end
    endtask

    task automatic test_mismatch();
        cfg_write(0, 84, 7);
        cfg_write(1, 100, 25);
        do_start(2);
        do_store(84, 7);
        tests++; if (store_count !== 4'd1 || busy !== 1'b1) begin fails++; $display("FAIL mm_first sc=%0d busy=%0d exp=1,1", store_count, busy); end
        do_store(100, 24);
        tests++; if (done !== 1'b1 || pass !== 1'b0) begin fails++; $display("FAIL mm_state done=%0d pass=%0d exp=1,0", done, pass); end
        tests++; if (fail_code !== 2'd1) begin fails++; $display("FAIL mm_fc got=%0d exp=1", fail_code); end
        tests++; if (mismatch_idx !== 3'd1) begin fails++; $display("FAIL mm_idx got=%0d exp=1", mismatch_idx); end
        tests++; if (store_count !== 4'd1) begin fails++; $display("FAIL mm_sc got=%0d exp=1", store_count); end
        do_clear();
    endtask

    task automatic test_timeout();
        cfg_write(0, 100, 25);
        do_start(1);
        repeat (239) @(negedge clk);
        tests++; if (busy !== 1'b1 || cycle_count !== 8'd239) begin fails++; $display("FAIL to_pre busy=%0d cc=%0d exp=1,239", busy, cycle_count); end
        @(negedge clk);
        tests++; if (done !== 1'b1 || fail_code !== 2'd2) begin fails++; $display("FAIL to_fc done=%0d fc=%0d exp=1,2", done, fail_code); end
        tests++; if (cycle_count !== 8'd239) begin fails++; $display("FAIL to_cc got=%0d exp=239", cycle_count); end
        do_clear();
        do_start(1);
        repeat (239) @(negedge clk);
        do_store(100, 25);
        tests++; if (pass !== 1'b1 || fail_code !== 2'd0) begin fails++; $display("FAIL to_win pass=%0d fc=%0d exp=1,0", pass, fail_code); end
        do_clear();
    endtask

    task automatic test_badcfg();
        do_start(0);
        tests++; if (done !== 1'b1 || fail_code !== 2'd3 || cycle_count !== 8'd0) begin fails++; $display("FAIL bad0 done=%0d fc=%0d cc=%0d exp=1,3,0", done, fail_code, cycle_count); end
        do_clear();
        do_start(9);
        tests++; if (done !== 1'b1 || fail_code !== 2'd3 || busy !== 1'b0) begin fails++; $display("FAIL bad9 done=%0d fc=%0d busy=%0d exp=1,3,0", done, fail_code, busy); end
        do_clear();
        tests++; if (fail_code !== 2'd0 || done !== 1'b0) begin fails++; $display("FAIL bad_clr fc=%0d done=%0d exp=0,0", fail_code, done); end
    endtask

    task automatic test_reset_mid_run();
        cfg_write(0, 84, 7);
        cfg_write(1, 100, 25);
        do_start(2);
        do_store(84, 7);
        #2 rst_n = 1'b0;
        #1;
        tests++; if (busy !== 1'b0 || done !== 1'b0 || store_count !== 4'd0 || cycle_count !== 8'd0) begin fails++; $display("FAIL mid_rst busy=%0d done=%0d sc=%0d cc=%0d exp=0", busy, done, store_count, cycle_count); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mid_idle done=%0d busy=%0d exp=0,0", done, busy); end
        do_start(2);
        do_store(84, 7);
        do_store(100, 25);
        tests++; if (pass !== 1'b1 || store_count !== 4'd2) begin fails++; $display("FAIL mid_rerun pass=%0d sc=%0d exp=1,2", pass, store_count); end
        do_clear();
    endtask

    task automatic test_cfg_ignored_in_run();
        cfg_write(0, 100, 25);
        do_start(1);
        cfg_write(0, 1, 1);
        do_store(100, 25);
        tests++; if (pass !== 1'b1) begin fails++; $display("FAIL cfg_run pass=%0d exp=1", pass); end
        do_clear();
    endtask

    task automatic test_clear_in_run();
        do_start(1);
        repeat (3) @(negedge clk);
        do_clear();
        tests++; if (busy !== 1'b0 || done !== 1'b0 || fail_code !== 2'd0) begin fails++; $display("FAIL clr_run busy=%0d done=%0d fc=%0d exp=0", busy, done, fail_code); end
    endtask

    task automatic test_start_clear();
        start = 1'b1; clear = 1'b1; cfg_count = 4'd1;
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL st_clr busy=%0d done=%0d exp=0,0", busy, done); end
        repeat (2) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL st_clr2 busy=%0d exp=0", busy); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_pass();
        test_mismatch();
        test_timeout();
        test_badcfg();
        test_reset_mid_run();
        test_cfg_ignored_in_run();
        test_clear_in_run();
        test_start_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
